// File: rtl/issue_steer_reg_if.sv
// issue_steer_reg_if
//   Bundles the issue-group input bus and the per-lane EXE output bus of
//   issue_steer_reg.
//   master : upstream/downstream side (drives in_*, observes in_ready, ex_*)
//   slave  : issue_steer_reg itself
//   in_valid/in_type/in_data : per-slot group, slot 0 oldest
//   in_ready                 : group accepted this cycle
//   ex_valid/ex_type/ex_data : per-lane registered issue to EXE
interface issue_steer_reg_if #(
    parameter int LANES = 2,
    parameter int DW    = 128,
    parameter int TW    = 10
);
    logic [LANES-1:0]    in_valid;
    logic [LANES*TW-1:0] in_type;
    logic [LANES*DW-1:0] in_data;
    logic                in_ready;
    logic [LANES-1:0]    ex_valid;
    logic [LANES*TW-1:0] ex_type;
    logic [LANES*DW-1:0] ex_data;

    modport master (
        output in_valid, in_type, in_data,
        input  in_ready, ex_valid, ex_type, ex_data
    );

    modport slave (
        input  in_valid, in_type, in_data,
        output in_ready, ex_valid, ex_type, ex_data
    );
endinterface

// File: rtl/issue_steer_reg.sv
// issue_steer_reg
//   Issue-stage steering register. Simple ALU entries fill the low lanes in
//   program order; the first non-simple entry is steered to lane LANES-1 (the
//   only lane with mul/div/CSR/ertn units). Younger entries behind it are
//   parked in a pending buffer and drained in later cycles, during which new
//   groups are refused.
//   clk       : clock, rising edge
//   rstn      : synchronous active-low reset
//   bus       : issue_steer_reg_if.slave (input group + EXE lanes)
//   stall     : downstream stall, freezes everything
//   flush     : mispredict flush, clears lanes and pending buffer
//   split_cnt : saturating count of group-split events
module issue_steer_reg #(
    parameter int LANES = 2,
    parameter int DW    = 128,
    parameter int TW    = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    issue_steer_reg_if.slave     bus,
    input  logic                 stall,
    input  logic                 flush,
    output logic [15:0]          split_cnt
);
    localparam int PW = LANES - 1;
    localparam logic [TW-1:0] TYPE_SIMPLE = TW'(1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t              state;
    logic [PW-1:0]       pend_valid;
    logic [TW-1:0]       pend_type [PW];
    logic [DW-1:0]       pend_data [PW];
    logic [LANES-1:0]    ex_valid_q;
    logic [LANES*TW-1:0] ex_type_q;
    logic [LANES*DW-1:0] ex_data_q;

    logic [LANES-1:0]    src_valid;
    logic [TW-1:0]       src_type [LANES];
    logic [DW-1:0]       src_data [LANES];
    logic [LANES-1:0]    live;

    logic [LANES-1:0]    nxt_valid;
    logic [LANES*TW-1:0] nxt_type;
    logic [LANES*DW-1:0] nxt_data;
    logic [PW-1:0]       rem_valid;
    logic [TW-1:0]       rem_type [PW];
    logic [DW-1:0]       rem_data [PW];
    logic                found;
    int                  k;

    assign bus.in_ready = rstn & ~stall & ~flush & (state == RUN);
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_type  = ex_type_q;
    assign bus.ex_data  = ex_data_q;

    // The pending buffer is always a prefix, so in DRAIN the top slot is
    // simply empty.
    always_comb begin
        src_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            src_type[i] = '0;
            src_data[i] = '0;
        end
        if (state == DRAIN) begin
            for (int i = 0; i < PW; i++) begin
                src_valid[i] = pend_valid[i];
                src_type[i]  = pend_type[i];
                src_data[i]  = pend_data[i];
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                src_valid[i] = bus.in_valid[i];
                src_type[i]  = bus.in_type[i*TW +: TW];
                src_data[i]  = bus.in_data[i*DW +: DW];
            end
        end
        live[0] = src_valid[0];
        for (int i = 1; i < LANES; i++) begin
            live[i] = live[i-1] & src_valid[i];
        end
    end

    // Entries before the first non-simple one keep their own lane index, so
    // the lane order matches age order; everything behind it is repacked
    // from pending slot 0.
    always_comb begin
        nxt_valid = '0;
        nxt_type  = '0;
        nxt_data  = '0;
        rem_valid = '0;
        for (int i = 0; i < PW; i++) begin
            rem_type[i] = '0;
            rem_data[i] = '0;
        end
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < LANES; i++) begin
            if (live[i]) begin
                if (!found) begin
                    if (src_type[i] == TYPE_SIMPLE) begin
                        nxt_valid[i]           = 1'b1;
                        nxt_type[i*TW +: TW]   = src_type[i];
                        nxt_data[i*DW +: DW]   = src_data[i];
                    end else begin
                        found                          = 1'b1;
                        k                              = i;
                        nxt_valid[LANES-1]             = 1'b1;
                        nxt_type[(LANES-1)*TW +: TW]   = src_type[i];
                        nxt_data[(LANES-1)*DW +: DW]   = src_data[i];
                    end
                end else begin
                    rem_valid[i-k-1] = 1'b1;
                    rem_type[i-k-1]  = src_type[i];
                    rem_data[i-k-1]  = src_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= RUN;
            ex_valid_q <= '0;
            ex_type_q  <= '0;
            ex_data_q  <= '0;
            pend_valid <= '0;
            split_cnt  <= '0;
        end else if (flush) begin
            state      <= RUN;
            ex_valid_q <= '0;
            ex_type_q  <= '0;
            ex_data_q  <= '0;
            pend_valid <= '0;
        end else if (!stall) begin
            ex_valid_q <= nxt_valid;
            ex_type_q  <= nxt_type;
            ex_data_q  <= nxt_data;
            pend_valid <= rem_valid;
            pend_type  <= rem_type;
            pend_data  <= rem_data;
            if (|rem_valid) begin
                state <= DRAIN;
                if (split_cnt != 16'hFFFF) begin
                    split_cnt <= split_cnt + 16'd1;
                end
            end else begin
                state <= RUN;
            end
        end
    end
endmodule

// File: doc/issue_steer_reg.md
ISSUE_STEER_REG -- requirements
Module: issue_steer_reg

Interface
REQ-001 Parameter LANES, default 2, issue width (legal 2..4); lane LANES-1 is the only lane with special units (mul/div/CSR/ertn).
REQ-002 Parameter DW, default 128, per-slot opaque payload width (decoded fields, operands, PC).
REQ-003 Parameter TW, default 10, per-slot one-hot instruction-type width; type 'h001 = simple ALU.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  LANES  per-slot valid; slot 0 oldest.
REQ-007 in_type  in  LANES*TW  per-slot instruction type; slot i at [i*TW +: TW].
REQ-008 in_data  in  LANES*DW  per-slot payload; slot i at [i*DW +: DW].
REQ-009 in_ready  out  1  group accepted this cycle when high.
REQ-010 stall  in  1  downstream stall (DCache/div).
REQ-011 flush  in  1  branch-mispredict flush.
REQ-012 ex_valid  out  LANES  per-lane valid to EXE.
REQ-013 ex_type  out  LANES*TW  per-lane type; zero when lane invalid.
REQ-014 ex_data  out  LANES*DW  per-lane payload; zero when lane invalid.
REQ-015 split_cnt  out  16  count of group-split events, saturating.

Function
REQ-016 Valid source entries are the contiguous prefix of valid slots from slot 0; slots after the first invalid slot are ignored.
REQ-017 An entry is simple iff its type == 'h001; any other value, zero included, is non-simple.
REQ-018 State RUN: the source is the input slots. State DRAIN: the source is the pending buffer, which holds up to LANES-1 entries oldest-first.
REQ-019 in_ready = rstn & ~stall & ~flush & (state==RUN); input is consumed only when in_ready=1.
REQ-020 Steering: let n = valid source count, k = index of the first non-simple entry.
REQ-021 No non-simple entry: entries 0..n-1 go to lanes 0..n-1 in order, and no split occurs.
REQ-022 Non-simple at k: entries 0..k-1 go to lanes 0..k-1, entry k goes to lane LANES-1, and lanes k..LANES-2 are invalid.
REQ-023 Entries k+1..n-1 are written to the pending buffer in order. If their count is >0: state goes to DRAIN and split_cnt increments.
REQ-024 DRAIN applies REQ-020..023 to the pending buffer, which may split again. The pending buffer is replaced by any new remainder. The state returns to RUN when no remainder is left.
REQ-025 Latency: a steered entry appears on ex_* exactly 1 cycle after it is accepted or drained.
REQ-026 RUN with no valid input and no stall/flush: ex_valid goes to 0 next cycle.
REQ-027 stall=1, flush=0: ex_*, pending buffer, state and split_cnt all hold.
REQ-028 flush=1 has priority over stall. Next cycle: ex_valid, ex_type and ex_data are 0, the pending buffer is emptied, the state is RUN, and split_cnt holds.
REQ-029 split_cnt saturates at 16'hFFFF. It is not cleared by flush.
REQ-030 Program order is preserved: every entry issued in cycle t is older than every entry issued in cycle t+1, and lanes are age-ordered 0..LANES-1 among valid lanes.

Reset
REQ-031 While rstn=0 at a clock edge: ex_valid, ex_type, ex_data and split_cnt become 0, the state becomes RUN and the pending buffer is emptied.
REQ-032 in_ready is 0 while rstn=0.
REQ-033 Reset asserted mid-DRAIN discards pending entries with no further issue.

Verification
REQ-034 LANES=2, slots {ALU A, ALU B} -> next cycle ex_valid=2'b11, lane0=A, lane1=B; in_ready stays 1.
REQ-035 LANES=2, slots {DIV 'h008 A, ALU B}:
- cycle1: ex_valid=2'b10, lane1=A, in_ready=0;
- cycle2: ex_valid=2'b01, lane0=B, split_cnt=1, in_ready=1.
REQ-036 LANES=2, slots {ALU A, MUL 'h004 B} -> ex_valid=2'b11, lane0=A, lane1=B; split_cnt unchanged.
REQ-037 LANES=4, slots {ALU P, DIV Q, ALU R, ERTN 'h020 S}:
- cycle1: ex_valid=4'b1001, lane0=P, lane3=Q;
- cycle2: ex_valid=4'b1001, lane0=R, lane3=S;
- split_cnt=1; lanes 1-2 have type/data 0.
REQ-038 Case of REQ-035 with stall=1 held 3 cycles during DRAIN -> outputs frozen; then flush=1 with stall=1 -> next cycle ex_valid=0, in_ready=1, B never issued.
REQ-039 rstn=0 for one cycle mid-DRAIN (split_cnt=5) -> ex_valid=0, split_cnt=0, in_ready=1 the cycle after release.
